fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the instruction-fetch stage: owns the PC register and issues req/ack fetches to instruction memory.
//  Holds one fetched instruction in a 1-entry output buffer for decode. Honours decode stall and MEM-stage redirect.
//  Sits between branch resolution (MEM) / hazard logic (ID) and instruction memory; replaces the free-running PC+mux.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; first fetch address
//  PERF_W     32             width of performance counters (FETCH_PERF_EN only)
// PORTS
//  clk             in   1   pipeline clock, all state on posedge
//  rst             in   1   asynchronous, active-high reset
//  redirect_valid  in   1   MEM stage requests PC change (taken branch/jump)
//  redirect_pc     in   32  target PC; bits [1:0] forced to 0 internally
//  stall           in   1   decode cannot accept if_instr this cycle
//  imem_req        out  1   fetch request to instruction memory
//  imem_addr       out  32  fetch address, word aligned
//  imem_ack        in   1   memory returns imem_rdata this cycle
//  imem_rdata      in   32  fetched instruction word
//  if_valid        out  1   if_pc/if_instr hold a valid instruction
//  if_pc           out  32  PC of buffered instruction
//  if_instr        out  32  buffered instruction; NOP 32'h0000_0013 when !if_valid
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, state=S_BOOT, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP.
//  Handshake: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1; ack without req is ignored.
//  Consume: buffer drained when if_valid & !stall. Buffer "free" = !if_valid | consume (same-cycle refill allowed).
//  States (fetch_pkg::fetch_state_t):
//   S_BOOT : one cycle after reset release, no req -> S_REQ.
//   S_REQ  : imem_req = buffer free (or already issued); imem_addr=pc.
//            ack & !redirect -> if_pc<=pc, if_instr<=imem_rdata, if_valid<=1, pc<=pc+4; stay S_REQ.
//            redirect & no outstanding req -> pc<=redirect_pc, if_valid<=0, stay S_REQ.
//            redirect & req issued & !ack -> latch target, if_valid<=0, -> S_DRAIN.
//            redirect & ack same cycle -> data discarded, pc<=redirect_pc, if_valid<=0.
//   S_DRAIN: keep old req/addr until ack; ack data discarded; then pc<=latched target -> S_REQ.
//            further redirect in S_DRAIN overwrites latched target (last wins).
//  Priority: rst > redirect > ack capture > stall hold.
//  Stall: if_valid/if_pc/if_instr held unchanged; no new req while buffer full and not consumed.
//  Redirect always flushes buffer (if_valid<=0) even when stall=1.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no carry out.
//  Latency: req->capture = memory latency; capture->if_valid visible next cycle; redirect->first req at target
//   next cycle (S_REQ) or cycle after drain ack (S_DRAIN). Zero-wait memory sustains 1 instr/cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[PERF_W-1:0] (instructions captured and kept),
//   perf_stall_cnt[PERF_W-1:0] (cycles if_valid&stall); saturating, cleared by rst.
//  FETCH_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  fetch_pkg: fetch_state_t {S_BOOT,S_REQ,S_DRAIN}, PC_STEP=32'd4, INSTR_NOP=32'h0000_0013.
//  Sub-module fetch_perf_cnt (saturating counter, PERF_W param), instantiated only under FETCH_PERF_EN.
// TESTING
//  1 Zero-wait mem (ack=req), no stall, rst release -> if_pc 0,4,8,... one per cycle from 2nd cycle after BOOT.
//  2 2-cycle ack latency -> imem_addr stable during wait; if_valid pulses every 2 cycles with correct instr.
//  3 stall=1 for 3 cycles while if_valid -> if_pc/if_instr unchanged, imem_req=0 after buffer fills.
//  4 redirect_pc=32'h100 during pending req -> S_DRAIN, old ack data dropped, next req addr 32'h100.
//  5 redirect with ack same cycle, redirect_pc=32'h203 -> data dropped, next imem_addr 32'h200.
//  6 pc=32'hFFFF_FFFC fetch -> next imem_addr 32'h0; rst mid-wait -> outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Provides the fetch FSM state type, the PC increment, the NOP encoding and a PC alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating event counter, cleared by rst.
// Ports: clk, rst (async, active-high), inc (count enable), cnt[PERF_W-1:0] (current count).
module fetch_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] cnt
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, runs the req/ack handshake to instruction
// memory and keeps one fetched instruction in an output buffer for decode.
// Ports: clk, rst (async, active-high); redirect_valid/redirect_pc from MEM; stall from decode;
//   imem_req/imem_addr out, imem_ack/imem_rdata in; if_valid/if_pc/if_instr to decode.
// Build option: define FETCH_PERF_EN to add perf_fetch_cnt/perf_stall_cnt (width PERF_W).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d;
    logic         issued_q, issued_d;

    logic         consume;
    logic         buf_free;
    logic         req;
    logic         capture;
    logic [31:0]  redir_pc;

    assign redir_pc = align_pc(redirect_pc);
    assign consume  = if_valid_q & ~stall;
    assign buf_free = ~if_valid_q | consume;

    // An issued request must be held until acked, even if the buffer has since filled.
    always_comb begin
        unique case (state_q)
            S_REQ:   req = buf_free | issued_q;
            S_DRAIN: req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    assign capture = (state_q == S_REQ) & req & imem_ack & ~redirect_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        issued_d   = issued_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        if (consume) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    issued_d   = 1'b0;
                    // A request already on the bus cannot be withdrawn: drain it first.
                    if (req && !imem_ack) begin
                        tgt_d   = redir_pc;
                        state_d = S_DRAIN;
                    end else begin
                        pc_d = redir_pc;
                    end
                end else if (capture) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
                    pc_d       = pc_q + PC_STEP;
                    issued_d   = 1'b0;
                end else begin
                    issued_d = req;
                end
            end
            S_DRAIN: begin
                if_valid_d = 1'b0;
                if (redirect_valid) begin
                    tgt_d = redir_pc;
                end
                if (imem_ack) begin
                    pc_d     = redirect_valid ? redir_pc : tgt_q;
                    state_d  = S_REQ;
                    issued_d = 1'b0;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (!if_valid_d) begin
            if_instr_d = INSTR_NOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            issued_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= INSTR_NOP;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            issued_q   <= issued_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt #(
        .PERF_W(PERF_W)
    ) u_fetch_cnt (
        .clk(clk),
        .rst(rst),
        .inc(capture),
        .cnt(perf_fetch_cnt)
    );

    fetch_perf_cnt #(
        .PERF_W(PERF_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(if_valid_q & stall),
        .cnt(perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized bench for fetch_ctrl with a memory responder
// and an instruction-stream reference model (expected PC sequence plus memory contents).
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory responder state
    int  lat = 0;
    bit  lat_rand = 0;
    bit  spurious = 0;
    bit  pending = 0;
    int  wait_cnt = 0;
    bit  last_ack = 0;

    // reference model state
    logic [31:0] exp_pc = 32'h0;
    int          deliveries = 0;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = 32'h0;
    bit          prev_hold = 0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        stall = st;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        if (prev_pend) begin
            chk("req_hold", {31'h0, imem_req}, 32'h1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        if (prev_hold) begin
            chk("hold_valid", {31'h0, if_valid}, 32'h1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
        if (!if_valid) chk("nop_when_empty", if_instr, NOP);
        if (if_valid && st) chk("no_req_full", {31'h0, imem_req}, 32'h0);
        if (if_valid && !st) begin
            chk("stream_pc", if_pc, exp_pc);
            chk("stream_instr", if_instr, mem(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        last_ack = 0;
        if (imem_req) begin
            if (!pending) begin
                pending = 1;
                wait_cnt = lat_rand ? $urandom_range(lat, 0) : lat;
            end
            if (wait_cnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem(imem_addr);
                pending = 0;
                last_ack = 1;
            end else begin
                wait_cnt--;
                imem_ack = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            pending = 0;
            imem_ack = spurious && ($urandom_range(3, 0) == 0);
            imem_rdata = $urandom;
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        prev_hold = if_valid && st && !rv;
        prev_pc = if_pc;
        prev_instr = if_instr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        exp_pc = 32'h0;
        pending = 0;
        prev_pend = 0;
        prev_hold = 0;
    endtask

    initial begin
        bit found;

        // 1: zero-wait memory, one instruction per cycle
        lat = 0; lat_rand = 0; spurious = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t1_valid", {31'h0, if_valid}, (k >= 1) ? 32'h1 : 32'h0);
            if (k >= 1) chk("t1_pc", if_pc, 32'(4 * (k - 1)));
        end

        // 2: two-cycle ack latency, one instruction every two cycles
        lat = 1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t2_valid", {31'h0, if_valid},
                (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
            if (k >= 2 && k % 2 == 0) chk("t2_pc", if_pc, 32'(4 * (k / 2 - 1)));
        end

        // 3: stall holds the buffer and blocks new requests
        lat = 0;
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("t3_pc", if_pc, 32'h8);
            chk("t3_instr", if_instr, mem(32'h8));
            chk("t3_req", {31'h0, imem_req}, 32'h0);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);

        // 4: redirect while a request is outstanding drains it first
        lat = 3;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t4_drain_valid", {31'h0, if_valid}, 32'h0);
            found = last_ack;
        end
        chk("t4_drain_ack", {31'h0, found}, 32'h1);
        lat = 0;
        step(1'b0, 1'b0, 32'h0);
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_addr", imem_addr, 32'h100);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);

        // 5: redirect coincident with ack, misaligned target
        step(1'b0, 1'b1, 32'h203);
        chk("t5_ack_same", {31'h0, last_ack}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_addr", imem_addr, 32'h200);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);

        // 6: PC wrap-around, then reset in the middle of a wait
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_addr_wrap", imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);
        lat = 3;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        do_reset();

        // randomized traffic: variable latency, stalls, redirects, stray acks
        lat = 3; lat_rand = 1; spurious = 1;
        deliveries = 0;
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(9, 0) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0,
                 $urandom);
        end
        chk("rand_progress", {31'h0, deliveries > 100}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
